// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and stall counter width.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CW = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin first-set search.
// Returns the first asserted request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    // Walk offsets from far to near so the nearest set bit after ptr is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ requesters.
// A granted requester writes up to MAXBURST words, throttled by F_FullN, before
// ownership rotates. Every new grant costs one IDLE arbitration cycle.
// Optional build macro FIFO_WR_ARB_STALL_CNT_EN adds a saturating StallCnt output
// that counts cycles where the owner wanted to write but the FIFO was full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 32,
    parameter int MAXBURST = 4
) (
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic [NREQ-1:0]          ReqN,
    input  logic [NREQ*DWIDTH-1:0]   ReqData,
    input  logic                     ClrN,
    input  logic                     F_FullN,
    output logic [NREQ-1:0]          GntN,
    output logic                     FInN,
    output logic [DWIDTH-1:0]        Data_In,
    output logic                     FClrN,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    output logic [STALL_CW-1:0]      StallCnt,
`endif
    output logic                     Busy
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAXBURST) + 1;
    localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBURST - 1);

    arb_state_t    state, state_nx;
    logic [OW-1:0] owner, owner_nx;
    logic [OW-1:0] rr_ptr, rr_ptr_nx;
    logic [BW-1:0] beat_cnt, beat_cnt_nx;

    logic          wr_ok;
    logic [OW-1:0] pick_idx;
    logic          pick_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_rr_pick (
        .req   (~ReqN),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign Data_In = ReqData[owner*DWIDTH +: DWIDTH];
    assign FClrN   = ClrN;
    assign FInN    = ~wr_ok;
    assign Busy    = (state == ARB_BURST);

    // A word moves only when the owner is requesting, the FIFO has room and no clear is pending.
    always_comb begin
        wr_ok = (state == ARB_BURST) && !ReqN[owner] && F_FullN && ClrN;
    end

    // Only the owner's accept strobe can go low, and only on a real write.
    always_comb begin
        GntN        = '1;
        GntN[owner] = ~wr_ok;
    end

    // State, ownership, rotation pointer and beat counter registers.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    // Arbitration in IDLE, burst accounting and release detection in BURST; clear wins over both.
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        if (!ClrN) begin
            state_nx    = ARB_IDLE;
            beat_cnt_nx = '0;
            rr_ptr_nx   = '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_nx    = pick_idx;
                        beat_cnt_nx = '0;
                        state_nx    = ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (wr_ok) begin
                        beat_cnt_nx = beat_cnt + BW'(1);
                    end
                    if ((wr_ok && (beat_cnt == LAST_BEAT)) || ReqN[owner]) begin
                        state_nx  = ARB_IDLE;
                        rr_ptr_nx = (owner == LAST_IDX) ? '0 : owner + OW'(1);
                    end
                end
                default: begin
                    state_nx = ARB_IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    // Count owner cycles blocked by a full FIFO, saturating rather than wrapping.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            StallCnt <= '0;
        end else if (!ClrN) begin
            StallCnt <= '0;
        end else if ((state == ARB_BURST) && !ReqN[owner] && !F_FullN && (StallCnt != '1)) begin
            StallCnt <= StallCnt + STALL_CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
// Checks StallCnt as well when FIFO_WR_ARB_STALL_CNT_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DWIDTH   = 32;
    localparam int MAXBURST = 4;

    logic                   Clk = 1'b0;
    logic                   RstN;
    logic [NREQ-1:0]        ReqN;
    logic [NREQ*DWIDTH-1:0] ReqData;
    logic                   ClrN;
    logic                   F_FullN;
    logic [NREQ-1:0]        GntN;
    logic                   FInN;
    logic [DWIDTH-1:0]      Data_In;
    logic                   FClrN;
    logic                   Busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]            StallCnt;
`endif

    int errCount   = 0;
    int checkCount = 0;

    // Behavioural model: is a burst open, who owns it, where the next search starts.
    bit mBusy;
    int mOwner;
    int mPtr;
    int mBeats;
    int mStall;

    logic [NREQ-1:0] rq;
    logic            fullN, clrN, rstN;
    int              order[$];
    int              lens[$];
    logic            prevFin;
    int              w;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DWIDTH   (DWIDTH),
        .MAXBURST (MAXBURST)
    ) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .ReqN     (ReqN),
        .ReqData  (ReqData),
        .ClrN     (ClrN),
        .F_FullN  (F_FullN),
        .GntN     (GntN),
        .FInN     (FInN),
        .Data_In  (Data_In),
        .FClrN    (FClrN),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .StallCnt (StallCnt),
`endif
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int rrFirst(input logic [NREQ-1:0] reqN, input int from);
        for (int k = 0; k < NREQ; k++) begin
            if (!reqN[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mBusy  = 1'b0;
        mOwner = 0;
        mPtr   = 0;
        mBeats = 0;
        mStall = 0;
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic modelStep();
        bit wrote;
        int pick;
        if (!RstN) begin
            modelReset();
        end else if (!ClrN) begin
            mBusy  = 1'b0;
            mBeats = 0;
            mPtr   = 0;
            mStall = 0;
        end else if (!mBusy) begin
            pick = rrFirst(ReqN, mPtr);
            if (pick >= 0) begin
                mOwner = pick;
                mBeats = 0;
                mBusy  = 1'b1;
            end
        end else begin
            wrote = !ReqN[mOwner] && F_FullN;
            if (!ReqN[mOwner] && !F_FullN && mStall < 65535) mStall++;
            if (wrote) mBeats++;
            if (ReqN[mOwner] || (wrote && mBeats == MAXBURST)) begin
                mBusy = 1'b0;
                mPtr  = (mOwner + 1) % NREQ;
            end
        end
    endtask

    task automatic compareToModel();
        logic            wr;
        logic [NREQ-1:0] g;
        wr = mBusy && !ReqN[mOwner] && F_FullN && ClrN;
        g  = '1;
        if (wr) g[mOwner] = 1'b0;
        checkOutput("GntN", 64'(GntN), 64'(g));
        checkOutput("FInN", 64'(FInN), 64'(!wr));
        checkOutput("Data_In", 64'(Data_In), 64'(ReqData[mOwner*DWIDTH +: DWIDTH]));
        checkOutput("Busy", 64'(Busy), 64'(mBusy));
        checkOutput("FClrN", 64'(FClrN), 64'(ClrN));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        checkOutput("StallCnt", 64'(StallCnt), 64'(mStall));
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, then check settled outputs.
    task automatic applyStimulus(input logic [NREQ-1:0] reqN, input logic fN, input logic cN, input logic rN);
        @(negedge Clk);
        ReqN    = reqN;
        F_FullN = fN;
        ClrN    = cN;
        RstN    = rN;
        for (int i = 0; i < NREQ; i++) ReqData[i*DWIDTH +: DWIDTH] = $urandom;
        #1;
        if (!RstN) modelReset();
        compareToModel();
        modelStep();
    endtask

    task automatic doReset();
        repeat (2) begin
            applyStimulus('1, 1'b1, 1'b1, 1'b0);
            checkOutput("rst_fin", 64'(FInN), 64'd1);
            checkOutput("rst_gnt", 64'(GntN), 64'hF);
            checkOutput("rst_busy", 64'(Busy), 64'd0);
        end
    endtask

    initial begin
        RstN    = 1'b0;
        ReqN    = '1;
        ReqData = '0;
        ClrN    = 1'b1;
        F_FullN = 1'b1;
        modelReset();

        // Reset then idle.
        doReset();
        repeat (10) begin
            applyStimulus('1, 1'b1, 1'b1, 1'b1);
            checkOutput("idle_fin", 64'(FInN), 64'd1);
        end

        // All requesters active: grant order and burst lengths.
        doReset();
        prevFin = 1'b1;
        for (int c = 0; c < 30; c++) begin
            applyStimulus('0, 1'b1, 1'b1, 1'b1);
            if (!FInN) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) if (!GntN[i]) w = i;
                if (prevFin) begin
                    order.push_back(w);
                    lens.push_back(1);
                end else begin
                    lens[lens.size()-1]++;
                end
            end
            prevFin = FInN;
        end
        checkOutput("rr_burst_count", 64'(order.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) checkOutput("rr_order", 64'(order[k]), 64'(k % NREQ));
        end
        for (int k = 0; k < 4; k++) begin
            if (k < lens.size()) checkOutput("rr_len", 64'(lens[k]), 64'(MAXBURST));
        end

        // Full stall on owner 2 after two beats.
        doReset();
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b1);
        repeat (2) begin
            applyStimulus(4'b1011, 1'b1, 1'b1, 1'b1);
            checkOutput("stall_pre", 64'(FInN), 64'd0);
        end
        repeat (3) begin
            applyStimulus(4'b1011, 1'b0, 1'b1, 1'b1);
            checkOutput("stall_fin", 64'(FInN), 64'd1);
        end
        repeat (2) begin
            applyStimulus(4'b1011, 1'b1, 1'b1, 1'b1);
            checkOutput("stall_resume", 64'(FInN), 64'd0);
        end
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b1);
        checkOutput("stall_bubble", 64'(Busy), 64'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        checkOutput("stall_cnt", 64'(StallCnt), 64'd3);
`endif

        // Early release by owner 0 while requester 3 waits.
        doReset();
        applyStimulus(4'b0110, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b0110, 1'b1, 1'b1, 1'b1);
        checkOutput("early_first", 64'(GntN), 64'hE);
        applyStimulus(4'b0111, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b0111, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b0111, 1'b1, 1'b1, 1'b1);
        checkOutput("early_rel_gnt", 64'(GntN), 64'h7);

        // Clear during owner 1's second beat.
        doReset();
        applyStimulus(4'b1101, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b1101, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'b1100, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_fin", 64'(FInN), 64'd1);
        checkOutput("clr_fclr", 64'(FClrN), 64'd0);
        checkOutput("clr_gnt", 64'(GntN), 64'hF);
        applyStimulus(4'b1100, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_idle", 64'(Busy), 64'd0);
        applyStimulus(4'b1100, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_next_gnt", 64'(GntN), 64'hE);

        // Randomized traffic with requests held until released.
        doReset();
        rq = '1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i]) rq[i] = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
                else       rq[i] = ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0;
            end
            fullN = ($urandom_range(0, 99) >= 20);
            clrN  = ($urandom_range(0, 99) >= 3);
            rstN  = ($urandom_range(0, 199) >= 1);
            applyStimulus(rq, fullN, clrN, rstN);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
